// File: rtl/clk_dv_multi.sv
// clk_dv_multi: N-channel programmable clock/tick divider with glitch-free deferred reload.
// Define CLKDV_PULSE_MODE_EN to add the per-channel pulse_mode input (one-cycle pulse outputs).
module clk_dv_multi #(
   parameter int                        NUM_CH    = 4,
   parameter int                        CNT_W     = 32,
   parameter logic [NUM_CH*CNT_W-1:0]   INIT_HALF = {32'd12500000, 32'd250000,
                                                     32'd25000000, 32'd50000000}
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic [NUM_CH-1:0]                             ch_en,
   input  logic                                          sync_restart,
   input  logic                                          cfg_valid,
   output logic                                          cfg_ready,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
   input  logic [CNT_W-1:0]                              cfg_half,
`ifdef CLKDV_PULSE_MODE_EN
   input  logic [NUM_CH-1:0]                             pulse_mode,
`endif
   output logic [NUM_CH-1:0]                             clk_out,
   output logic [NUM_CH-1:0]                             tick
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] w_pending;
   logic              w_cfg_ready;
   logic              w_accept;
   logic [CNT_W-1:0]  w_cfg_half_fix;

   // Out-of-range channel numbers match no pending bit, so they are always accepted.
   always_comb begin
      w_cfg_ready = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         if ((cfg_ch == CH_W'(i)) && w_pending[i]) w_cfg_ready = 1'b0;
      end
   end

   assign cfg_ready      = w_cfg_ready;
   assign w_accept       = cfg_valid && w_cfg_ready;
   assign w_cfg_half_fix = (cfg_half == '0) ? CNT_W'(1) : cfg_half;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      localparam logic [CNT_W-1:0] INIT_RAW = INIT_HALF[g*CNT_W +: CNT_W];
      localparam logic [CNT_W-1:0] INIT_FIX = (INIT_RAW == '0) ? CNT_W'(1) : INIT_RAW;

      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] r_half;
      logic [CNT_W-1:0] r_shadow;
      logic             r_pend;
      logic             r_phase;
      logic             r_tick;
      logic             r_out;
      logic             w_acc;
      logic             w_term;
      logic             w_pm;

      assign w_acc  = w_accept && (cfg_ch == CH_W'(g));
      assign w_term = (r_cnt == (r_half - CNT_W'(1)));

`ifdef CLKDV_PULSE_MODE_EN
      assign w_pm = pulse_mode[g];
`else
      assign w_pm = 1'b0;
`endif

      // NOTE: every state register, including the half/shadow values, takes the async reset
      // so a mid-run reset restores INIT_HALF and drops any pending reload.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt    <= '0;
            r_half   <= INIT_FIX;
            r_shadow <= INIT_FIX;
            r_pend   <= 1'b0;
            r_phase  <= 1'b0;
            r_tick   <= 1'b0;
            r_out    <= 1'b0;
         end else if (sync_restart) begin
            // NOTE: non-blocking assignments throughout, so every branch sees pre-edge state.
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_tick  <= 1'b0;
            r_out   <= 1'b0;
            r_pend  <= 1'b0;
            if (w_acc)       r_half <= w_cfg_half_fix;
            else if (r_pend) r_half <= r_shadow;
         end else if (!ch_en[g]) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_tick  <= 1'b0;
            r_out   <= 1'b0;
            if (r_pend) begin
               r_half <= r_shadow;
               r_pend <= 1'b0;
            end
            if (w_acc) begin
               r_shadow <= w_cfg_half_fix;
               r_pend   <= 1'b1;
            end
         end else if (w_term) begin
            // Toggle edge: a rise is also the tick, and the only point a reload may land.
            r_cnt   <= '0;
            r_phase <= ~r_phase;
            r_tick  <= ~r_phase;
            r_out   <= ~r_phase;
            if (r_pend) begin
               r_half <= r_shadow;
               r_pend <= 1'b0;
            end
            if (w_acc) begin
               r_shadow <= w_cfg_half_fix;
               r_pend   <= 1'b1;
            end
         end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_tick <= 1'b0;
            r_out  <= w_pm ? 1'b0 : r_phase;
            if (w_acc) begin
               r_shadow <= w_cfg_half_fix;
               r_pend   <= 1'b1;
            end
         end
      end

      assign w_pending[g] = r_pend;
      assign clk_out[g]   = r_out;
      assign tick[g]      = r_tick;
   end

endmodule

// File: tb/tb_clk_dv_multi.sv
// Randomized bench for clk_dv_multi against a countdown-based reference model.
// Builds with or without CLKDV_PULSE_MODE_EN.
module tb_clk_dv_multi;

   localparam int          NUM_CH = 4;
   localparam int          CNT_W  = 8;
   localparam logic [31:0] INIT   = {8'd4, 8'd3, 8'd2, 8'd1};

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NUM_CH-1:0] ch_en;
   logic              sync_restart;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [1:0]        cfg_ch;
   logic [CNT_W-1:0]  cfg_half;
   logic [NUM_CH-1:0] pulse_mode;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] tick;

   clk_dv_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .INIT_HALF(INIT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ch_en        (ch_en),
      .sync_restart (sync_restart),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_ch       (cfg_ch),
      .cfg_half     (cfg_half),
`ifdef CLKDV_PULSE_MODE_EN
      .pulse_mode   (pulse_mode),
`endif
      .clk_out      (clk_out),
      .tick         (tick)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: each channel counts down the cycles left in its current half-period.
   int m_half  [NUM_CH];
   int m_shadow[NUM_CH];
   int m_rem   [NUM_CH];
   bit m_pend  [NUM_CH];
   bit m_phase [NUM_CH];
   bit m_tick  [NUM_CH];
   int edges;

   function automatic int fix_half(input int h);
      return (h == 0) ? 1 : h;
   endfunction

   function automatic void m_reset();
      logic [31:0] init_v;
      init_v = INIT;
      for (int i = 0; i < NUM_CH; i++) begin
         m_half[i]   = fix_half(int'(init_v[i*8 +: 8]));
         m_shadow[i] = m_half[i];
         m_rem[i]    = m_half[i];
         m_pend[i]   = 1'b0;
         m_phase[i]  = 1'b0;
         m_tick[i]   = 1'b0;
      end
   endfunction

   function automatic bit m_ready();
      return !m_pend[int'(cfg_ch)];
   endfunction

   function automatic void m_step(input bit ready);
      for (int i = 0; i < NUM_CH; i++) begin
         bit acc;
         int fx;
         acc = cfg_valid && ready && (int'(cfg_ch) == i);
         fx  = fix_half(int'(cfg_half));
         if (sync_restart) begin
            m_phase[i] = 1'b0;
            m_tick[i]  = 1'b0;
            if (acc)            m_half[i] = fx;
            else if (m_pend[i]) m_half[i] = m_shadow[i];
            m_pend[i] = 1'b0;
            m_rem[i]  = m_half[i];
         end else if (!ch_en[i]) begin
            m_phase[i] = 1'b0;
            m_tick[i]  = 1'b0;
            if (m_pend[i]) begin
               m_half[i] = m_shadow[i];
               m_pend[i] = 1'b0;
            end
            if (acc) begin
               m_shadow[i] = fx;
               m_pend[i]   = 1'b1;
            end
            m_rem[i] = m_half[i];
         end else begin
            m_tick[i] = 1'b0;
            m_rem[i]--;
            if (m_rem[i] == 0) begin
               m_phase[i] = !m_phase[i];
               m_tick[i]  = m_phase[i];
               if (m_pend[i]) begin
                  m_half[i] = m_shadow[i];
                  m_pend[i] = 1'b0;
               end
               m_rem[i] = m_half[i];
            end
            if (acc) begin
               m_shadow[i] = fx;
               m_pend[i]   = 1'b1;
            end
         end
      end
      edges++;
   endfunction

   function automatic logic [NUM_CH-1:0] exp_tick();
      logic [NUM_CH-1:0] v;
      for (int i = 0; i < NUM_CH; i++) v[i] = m_tick[i];
      return v;
   endfunction

   // Model state is updated at the edge, using the pulse_mode value held over that edge.
   logic [NUM_CH-1:0] pm_at_edge;

   function automatic logic [NUM_CH-1:0] exp_out();
      logic [NUM_CH-1:0] v;
      for (int i = 0; i < NUM_CH; i++) v[i] = pm_at_edge[i] ? m_tick[i] : m_phase[i];
      return v;
   endfunction

   task automatic drive(input bit directed);
      if (directed) begin
         ch_en        = '1;
         sync_restart = 1'b0;
         cfg_valid    = 1'b0;
         cfg_ch       = 2'd0;
         cfg_half     = '0;
`ifdef CLKDV_PULSE_MODE_EN
         pulse_mode   = 4'b1000;
`else
         pulse_mode   = '0;
`endif
      end else begin
         for (int i = 0; i < NUM_CH; i++)
            if ($urandom_range(0, 31) == 0) ch_en[i] = ~ch_en[i];
         sync_restart = ($urandom_range(0, 49) == 0);
         cfg_valid    = ($urandom_range(0, 2) == 0);
         cfg_ch       = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) cfg_half = 8'($urandom_range(8, 20));
         else                            cfg_half = 8'($urandom_range(0, 6));
`ifdef CLKDV_PULSE_MODE_EN
         for (int i = 0; i < NUM_CH; i++)
            if ($urandom_range(0, 63) == 0) pulse_mode[i] = ~pulse_mode[i];
`else
         pulse_mode = '0;
`endif
      end
   endtask

   initial begin
      bit r;
      ch_en        = '1;
      sync_restart = 1'b0;
      cfg_valid    = 1'b0;
      cfg_ch       = 2'd0;
      cfg_half     = '0;
      pulse_mode   = '0;
      pm_at_edge   = '0;
      edges        = 0;
      m_reset();

      repeat (3) @(negedge clk);
      check("reset_clk_out", clk_out, 0);
      check("reset_tick", tick, 0);
      check("reset_cfg_ready", cfg_ready, 1);

      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst_n = 1'b1;
         check("clk_out", clk_out, exp_out());
         check("tick", tick, exp_tick());
         if (cyc < 24) begin
`ifdef CLKDV_PULSE_MODE_EN
            check("dir_ch3_out", clk_out[3], (edges % 8) == 4);
`else
            check("dir_ch3_out", clk_out[3], (edges / 4) % 2);
`endif
            check("dir_ch0_out", clk_out[0], edges % 2);
            check("dir_ch3_tick", tick[3], (edges % 8) == 4);
         end
         drive(cyc < 24);
         #1;
         r = m_ready();
         check("cfg_ready", cfg_ready, r);
         if (cyc >= 24 && (cyc == 1500 || $urandom_range(0, 399) == 0)) begin
            #2 rst_n = 1'b0;
            #1;
            check("async_rst_clk_out", clk_out, 0);
            check("async_rst_tick", tick, 0);
            check("async_rst_cfg_ready", cfg_ready, 1);
            m_reset();
            edges = 0;
            @(posedge clk);
         end else begin
            @(posedge clk);
            pm_at_edge = pulse_mode;
            m_step(r);
         end
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/clk_dv_multi.md
Name: clk_dv_multi

Overview:
- Parameterised N-channel clock/tick generator and successor to the fixed four-output divider.
- Each channel has a runtime-programmable half-period, a per-channel enable, and a glitch-free deferred reload.
- All channels have a shared synchronous restart for phase alignment.
- Feeds slow enables (reel spin, blink, display mux) to the rest of the slot-machine datapath.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 32, width of counters and half-period registers.
- INIT_HALF, {32'd12500000, 32'd250000, 32'd25000000, 32'd50000000}, flattened NUM_CH*CNT_W reset half-periods; channel i is slice [i*CNT_W +: CNT_W].

Ports:
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  asynchronous active-low reset.
- ch_en  in  NUM_CH  per-channel run enable, level.
- sync_restart  in  1  one-cycle pulse; realigns all channels.
- cfg_valid  in  1  reload request.
- cfg_ready  out  1  reload accept; combinational, equals ~pending[cfg_ch].
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel; values >= NUM_CH are accepted and ignored.
- cfg_half  in  CNT_W  new half-period in clk cycles; 0 is stored as 1.
- clk_out  out  NUM_CH  divided square outputs, registered.
- tick  out  NUM_CH  one-cycle strobe, registered; high on the cycle clk_out[i] rises.

Behaviour:
- Reset (async assert, sync-safe deassert): clk_out=0, tick=0, counters=0, half[i]=INIT_HALF slice (0 stored as 1), pending=0, so cfg_ready=1.
- Running channel (ch_en[i]=1):
  - Counter increments each cycle.
  - When cnt==half[i]-1: cnt<=0 and clk_out[i] toggles.
  - Period is exactly 2*half[i] cycles, 50% duty.
  - First rise occurs on the half[i]-th clk edge after enable or reset release.
- tick[i] is high for exactly one cycle, coincident with each 0->1 transition of clk_out[i]; it is low otherwise.
- half=1: clk_out toggles every cycle; tick pulses every 2 cycles.
- Reload handshake:
  - Transfer occurs when cfg_valid && cfg_ready.
  - cfg_half is captured into shadow[cfg_ch] and pending[cfg_ch] is set.
  - Pending shadow loads into half[i] at that channel's next terminal count, in the same cycle as the toggle, so the current half-period always completes.
  - pending clears there; cfg_ready for that channel returns high the following cycle.
  - A second request to a pending channel stalls (cfg_ready=0) until the first is applied.
- Disabled channel (ch_en[i]=0):
  - cnt held at 0, clk_out[i]=0, tick[i]=0.
  - Any pending shadow is applied on the next cycle.
  - A request to a disabled channel is applied one cycle after acceptance.
- Disable mid-period: output drops to 0 on the next edge; partial count is discarded.
- sync_restart: on the next edge all channels set cnt=0 and clk_out=0, tick=0, and apply all pending shadows.
- sync_restart has priority over terminal-count toggles in the same cycle.
- sync_restart coincident with an accepted reload: the new value is applied immediately, pending is left clear.
- Terminal count and reload acceptance on the same channel in the same cycle: the toggle uses the old half; the new value waits for the following terminal count.
- Comparison is against half[i]-1 using CNT_W-bit arithmetic. No wrap is possible because half>=1.

Optional Feature:
- Macro CLKDV_PULSE_MODE_EN.
- Defined:
  - Adds input port pulse_mode [NUM_CH].
  - Channels with pulse_mode[i]=1 drive clk_out[i] as a one-cycle pulse every 2*half[i] cycles, coincident with tick[i]; the internal phase still toggles.
  - pulse_mode is sampled each cycle, so a mode change takes effect on the next edge.
- Undefined: port absent; all channels square.

Test Plan:
- Setup for all scenarios: CNT_W=8, NUM_CH=4, INIT_HALF={4,3,2,1}, ch_en=4'hF after reset.
- Reset/free-run: release rst_n -> clk_out[3] rises at edge 4, period 8; ch0 period 2; tick pulses 1 cycle per rise; all outputs 0 during reset.
- Reload deferral: ch3 mid-period at cnt=1, send cfg_half=6 -> current half finishes at 4 cycles, next half is 6; cfg_ready low until the apply, high one cycle later; a second request stalls.
- Zero/min: cfg_half=0 on ch1 -> behaves as half=1, toggles every cycle, tick every 2 cycles.
- Enable/restart: drop ch_en[2] mid-high -> clk_out[2]=0 next edge. Pulse sync_restart while ch1 is at terminal count -> all counts 0, no toggle; all channels rise together half[i] edges later.
- Async reset mid-operation: assert rst_n low between edges -> outputs 0 immediately; a pending reload is discarded; INIT_HALF is restored.
- CLKDV_PULSE_MODE_EN: ch3 pulse_mode=1 -> clk_out[3] is high 1 cycle every 8.
